// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt receiver/aggregator.
//   Latches per-source requests (edge or level mode) as pending events.
//   Applies a mask and presents one prioritized request (lowest index wins)
//   to the CPU. A claim/complete handshake runs over a 4-entry register port.
//
// Ports:
//   clk      system clock
//   rstn     asynchronous reset, active-high (1 = reset asserted)
//   irq_src  per-source request lines, synchronous to clk
//   addr     register select: 0 PENDING, 1 MASK, 2 MODE, 3 CLAIM
//   we, re   one-cycle write / read strobes
//   wdata    write data
//   rdata    read data, combinational from addr while re=1, else 0
//   irq      registered aggregated interrupt request
module irq_ctrl #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_SRC-1:0] irq_src,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic             re,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             irq
);

   typedef enum logic [1:0] {
      REG_PENDING = 2'd0,
      REG_MASK    = 2'd1,
      REG_MODE    = 2'd2,
      REG_CLAIM   = 2'd3
   } reg_sel_e;

   logic [N_SRC-1:0] r_src_d;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_mask;
   logic [N_SRC-1:0] r_mode;
   logic             r_in_service;
   logic [ID_W-1:0]  r_claim_id;
   logic             r_irq;

   reg_sel_e         w_sel;
   logic [N_SRC-1:0] w_set;
   logic [N_SRC-1:0] w_active;
   logic [N_SRC-1:0] w_clr;
   logic [N_SRC-1:0] w_pending_nxt;
   logic             w_any;
   logic [ID_W-1:0]  w_win_id;
   logic             w_claim;
   logic             w_complete;
   logic             w_unused_wdata;

   assign w_sel          = reg_sel_e'(addr);
   // Only the low wdata bits carry meaning; fold the rest into a sink.
   assign w_unused_wdata = ^wdata;

   // Edge-mode bits need a rising edge; level-mode bits set while high.
   assign w_set    = irq_src & ~(r_mode & r_src_d);
   assign w_active = r_pending & r_mask;
   assign w_any    = |w_active;

   // Scan from the top down so the lowest active index is the last to win.
   always_comb begin
      w_win_id = '0;
      for (int unsigned i = N_SRC; i > 0; i--) begin
         if (w_active[i-1]) w_win_id = ID_W'(i - 1);
      end
   end

   assign w_claim    = re && (w_sel == REG_CLAIM) && !r_in_service && w_any;
   assign w_complete = we && (w_sel == REG_CLAIM) && r_in_service &&
                       (wdata[ID_W-1:0] == r_claim_id);

   always_comb begin
      w_clr = '0;
      if (we && (w_sel == REG_PENDING)) w_clr = wdata[N_SRC-1:0];
      if (w_claim) w_clr = w_clr | (N_SRC'(1) << w_win_id);
   end

   // Set is OR-ed in after the clear so a new request always survives.
   assign w_pending_nxt = (r_pending & ~w_clr) | w_set;

   always_comb begin
      rdata = '0;
      if (re) begin
         case (w_sel)
            REG_PENDING: rdata = 32'(r_pending);
            REG_MASK:    rdata = 32'(r_mask);
            REG_MODE:    rdata = 32'(r_mode);
            REG_CLAIM:   rdata = w_claim ? {1'b1, 31'(w_win_id)} : '0;
            default:     rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_src_d      <= '0;
         r_pending    <= '0;
         r_mask       <= '0;
         r_mode       <= '0;
         r_in_service <= 1'b0;
         r_claim_id   <= '0;
         r_irq        <= 1'b0;
      end else begin
         r_src_d   <= irq_src;
         r_pending <= w_pending_nxt;
         if (we && (w_sel == REG_MASK)) r_mask <= wdata[N_SRC-1:0];
         if (we && (w_sel == REG_MODE)) r_mode <= wdata[N_SRC-1:0];
         // A claim is only possible with in_service=0 and a completion only
         // with in_service=1, so the two never collide.
         if (w_claim) begin
            r_in_service <= 1'b1;
            r_claim_id   <= w_win_id;
         end else if (w_complete) begin
            r_in_service <= 1'b0;
         end
         r_irq <= w_any & ~r_in_service;
      end
   end

   assign irq = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic [N-1:0]  irq_src = '0;
   logic [1:0]    addr = '0;
   logic          we = 1'b0;
   logic          re = 1'b0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata;
   logic          irq;

   always #10 clk = ~clk;

   irq_ctrl #(.N_SRC(N), .ID_W(IDW)) dut (
      .clk(clk), .rstn(rstn), .irq_src(irq_src), .addr(addr),
      .we(we), .re(re), .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] q_rd[$];
   logic        q_irq[$];

   // Reference model: per-source arrays updated from the rules at each edge.
   bit m_pend[N];
   bit m_mask[N];
   bit m_mode[N];
   bit m_prev[N];
   bit m_insvc;
   int m_id;
   bit m_irq;

   function automatic int winner();
      for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] pack(input bit v[N]);
      logic [31:0] r = '0;
      for (int i = 0; i < N; i++) if (v[i]) r = r + (32'd1 << i);
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [1:0] a);
      int w;
      case (a)
         2'd0: return pack(m_pend);
         2'd1: return pack(m_mask);
         2'd2: return pack(m_mode);
         default: begin
            w = winner();
            if (!m_insvc && w >= 0) return 32'h8000_0000 + w;
            return 32'd0;
         end
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = 0; m_prev[i] = 0;
      end
      m_insvc = 0; m_id = 0; m_irq = 0;
   endtask

   task automatic model_edge(input logic w, input logic r, input logic [1:0] a,
                             input logic [31:0] d, input logic [N-1:0] s);
      int  win   = winner();
      int  claim = (r && a == 2'd3 && !m_insvc && win >= 0) ? win : -1;
      bit  done  = w && a == 2'd3 && m_insvc && (int'(d[IDW-1:0]) == m_id);
      bit  nirq  = (win >= 0) && !m_insvc;
      bit  setb, clrb;
      for (int i = 0; i < N; i++) begin
         setb = s[i] && (m_mode[i] ? !m_prev[i] : 1'b1);
         clrb = (w && a == 2'd0 && d[i]) || (claim == i);
         m_pend[i] = setb || (m_pend[i] && !clrb);
         if (w && a == 2'd1) m_mask[i] = d[i];
         if (w && a == 2'd2) m_mode[i] = d[i];
         m_prev[i] = s[i];
      end
      if (claim >= 0) begin
         m_insvc = 1; m_id = claim;
      end else if (done) begin
         m_insvc = 0;
      end
      m_irq = nirq;
   endtask

   // Called at posedge+1: drive one cycle of inputs, queue expectations.
   task automatic step(input logic w, input logic r, input logic [1:0] a,
                       input logic [31:0] d, input logic [N-1:0] s);
      we = w; re = r; addr = a; wdata = d; irq_src = s;
      if (r) q_rd.push_back(model_read(a));
      q_irq.push_back(m_irq);
      @(posedge clk);
      model_edge(w, r, a, d, s);
      cyc++;
      #1;
   endtask

   task automatic idle(input logic [N-1:0] s, input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 32'd0, s);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [N-1:0] s);
      step(1'b1, 1'b0, a, d, s);
   endtask

   task automatic rd(input logic [1:0] a, input logic [N-1:0] s);
      step(1'b0, 1'b1, a, 32'd0, s);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endtask

   // Assert reset between edges and check that state drops without a clock.
   task automatic async_reset_check();
      we = 0; re = 0; irq_src = '0;
      #2 rstn = 1'b1;
      #1 check("async_irq", {31'd0, irq}, 32'd0);
      re = 1'b1; addr = 2'd0;
      #1 check("async_pending", rdata, 32'd0);
      re = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b0;
   endtask

   // Monitor: read strobes are the output events for rdata; irq every cycle.
   initial begin
      logic [31:0] exp_rd;
      logic        exp_irq;
      forever begin
         @(negedge clk);
         if (q_irq.size() > 0) begin
            exp_irq = q_irq.pop_front();
            check("irq", {31'd0, irq}, {31'd0, exp_irq});
         end
         if (re) begin
            if (q_rd.size() == 0) begin
               check("rd_noexp", 32'd1, 32'd0);
            end else begin
               exp_rd = q_rd.pop_front();
               check($sformatf("rdata_a%0d", addr), rdata, exp_rd);
            end
         end else begin
            check("rdata_idle", rdata, 32'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      logic [N-1:0] s;
      logic [1:0]   a;
      logic         w, r;
      logic [31:0]  d;

      model_reset();
      repeat (3) @(posedge clk);
      #1 check("reset_irq", {31'd0, irq}, 32'd0);
      rstn = 1'b0;

      // reset state of every register
      for (int k = 0; k < 4; k++) rd(2'(k), '0);

      // level source 2: pending after 1 cycle, irq after 2
      wr(2'd1, 32'hF, '0);
      wr(2'd2, 32'h0, '0);
      step(0, 0, 0, 0, 4'b0100);
      rd(2'd0, 4'b0100);
      idle(4'b0100, 2);
      idle('0, 1);
      wr(2'd0, 32'hF, '0);
      idle('0, 2);

      // priority and claim/complete handshake
      idle(4'b1010, 1);
      idle('0, 2);
      rd(2'd3, '0);
      idle('0, 2);
      rd(2'd3, '0);
      wr(2'd3, 32'd1, '0);
      idle('0, 2);
      rd(2'd3, '0);
      idle('0, 1);
      wr(2'd3, 32'd3, '0);
      idle('0, 2);

      // edge mode: held line pends once, W1C sticks, low-then-high re-pends
      wr(2'd2, 32'h1, '0);
      for (int k = 0; k < 5; k++) rd(2'd0, 4'b0001);
      wr(2'd0, 32'h1, 4'b0001);
      rd(2'd0, 4'b0001);
      rd(2'd0, 4'b0001);
      idle('0, 1);
      idle(4'b0001, 1);
      rd(2'd0, 4'b0001);
      wr(2'd0, 32'hF, '0);
      wr(2'd2, 32'h0, '0);
      idle('0, 1);

      // level re-pend after W1C; set wins over clear on a new edge
      idle(4'b0100, 2);
      wr(2'd0, 32'h4, 4'b0100);
      rd(2'd0, 4'b0100);
      wr(2'd2, 32'h2, 4'b0100);
      wr(2'd0, 32'h2, 4'b0110);
      rd(2'd0, 4'b0110);
      idle('0, 1);
      wr(2'd0, 32'hF, '0);
      wr(2'd2, 32'h0, '0);
      idle('0, 2);

      // masking gates irq and claim but not PENDING
      idle(4'b0011, 1);
      wr(2'd1, 32'h0, '0);
      idle('0, 2);
      rd(2'd3, '0);
      rd(2'd0, '0);
      wr(2'd1, 32'h2, '0);
      idle('0, 2);
      rd(2'd3, '0);
      wr(2'd3, 32'd1, '0);
      wr(2'd1, 32'hF, '0);
      idle('0, 2);

      // claim 0, wrong-id completion ignored, then reset mid-service
      rd(2'd3, '0);
      wr(2'd3, 32'd2, '0);
      idle('0, 2);
      rd(2'd3, '0);
      async_reset_check();

      // in_service cleared by reset: a fresh claim succeeds
      wr(2'd1, 32'hF, '0);
      idle(4'b0101, 1);
      idle('0, 2);
      rd(2'd3, '0);
      step(1, 1, 2'd3, 32'd0, '0);
      idle('0, 3);
      async_reset_check();

      // randomized traffic
      s = '0;
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 2) == 0) s = N'($urandom_range(0, 15));
         w = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 1) == 1);
         a = 2'($urandom_range(0, 3));
         d = $urandom;
         if (w && a == 2'd1 && $urandom_range(0, 1) == 1) d = 32'hF;
         if (w && a == 2'd0 && $urandom_range(0, 1) == 1) d = d & 32'h1;
         step(w, r, a, d, s);
      end
      idle('0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
